posit_mult: RTL and testbench
=============================

// Module: posit_mult
// PURPOSE
//   Posit<N,es> multiplier with a single registered output stage: decodes two posits,
//   multiplies them, rounds the product back to an N-bit posit and flags NaR and zero.
//   Arithmetic leaf inside the posit datapath; accepts one operand pair per cycle.
// PARAMETERS
//   N    8   posit word width in bits (N >= 4)
//   es   3   exponent field width in bits (es < N-2)
//   Bs   log2(N)  derived (localparam) width of the regime-run counter
// PORTS
//   clk    in   1  system clock; all state updates on its rising edge
//   rst    in   1  synchronous, active-high reset
//   in1    in   N  posit operand A (two's-complement posit encoding)
//   in2    in   N  posit operand B
//   start  in   1  operands valid; sampled on the rising edge of clk
//   out    out  N  posit product, registered
//   inf    out  1  result is NaR (1 followed by N-1 zeros), registered
//   zero   out  1  result is exactly zero, registered
//   done   out  1  out/inf/zero hold the result of the previous start cycle
// BEHAVIOUR
// - Interface: one clock, clk. Reset rst is synchronous and active-high.
// - Reset: while rst=1 at a rising edge: out=0, inf=0, zero=0, done=0.
//   start in that same cycle is dropped. Reset mid-stream discards the pending result.
// - Latency 1: edge with start=1 and rst=0 registers the result of in1*in2 and sets done=1.
//   Edge with start=0 sets done=0; out, inf and zero hold their values.
//   With start held high, throughput is one result per cycle: done=1 each cycle.
// - Decode per operand:
//   - Negative operand (MSB=1): take the two's complement, then decode.
//   - Regime: run of identical bits after the sign. Run of m ones -> k=m-1; m zeros -> k=-m.
//   - Then es exponent bits (missing bits are zero) and the fraction with hidden leading 1.
// - Special cases (combinational, before the arithmetic):
//   - Either input 0x80..0 (NaR) -> out=NaR, inf=1, zero=0. NaR*0 is NaR.
//   - Else either input 0 -> out=0, zero=1, inf=0.
// - Arithmetic:
//   - sign = s1 ^ s2.
//   - scale = (k1+k2)*2^es + e1 + e2.
//   - Mantissa product is (N-es)x(N-es) unsigned; if product >= 2.0, shift right 1 and scale+1.
// - Encode:
//   - Regime from scale>>es, exponent = scale mod 2^es, then fraction.
//   - Truncate to N-1 magnitude bits; round to nearest, ties to even, using guard + sticky.
//   - Saturation: never round to zero or NaR. |result| > maxpos -> maxpos (0x7F for N=8);
//     0 < |result| < minpos -> minpos (0x01).
//   - Negative result = two's complement of the magnitude encoding.
// - inf and zero are mutually exclusive; both 0 for every finite nonzero product.
// - Result is commutative and bit-exact against the reference posit model (N=8, es=3).
// TESTING (N=8, es=3)
//   - rst=1 for 2 cycles, start=1 -> out=0x00, inf=0, zero=0, done=0.
//     done=1 at the first edge after rst drops.
//   - 0x40*0x44 (1.0*2.0) -> out=0x44. Next: 0xC0*0x40 (-1*1) -> 0xC0. done=1 each cycle.
//   - 0x42*0x42 (1.5*1.5=2.25, tie) -> out=0x44 (round to even).
//     0x42*0xC0 -> 0xBE (-1.5).
//   - 0x7F*0x7F -> 0x7F (maxpos sat); 0x01*0x01 -> 0x01 (minpos sat); 0x81*0x7F -> 0x81.
//   - 0x80*0x40 -> 0x80, inf=1. 0x00*0x80 -> 0x80, inf=1. 0x00*0x42 -> 0x00, zero=1.
//   - Exhaustive sweep of all 65536 pairs, start held high: compare out 1 cycle later.
//     Also deassert start for a cycle and check done=0 with out held.

Source files
------------

// File: rtl/posit_mult_if.sv
// Operand/result bundle for the posit multiplier: operand pair with start strobe,
// registered product with NaR/zero flags and done.
interface posit_mult_if #(
  parameter int N = 8
);
  logic [N-1:0] in1;
  logic [N-1:0] in2;
  logic         start;
  logic [N-1:0] out;
  logic         inf;
  logic         zero;
  logic         done;

  modport master (
    output in1, in2, start,
    input  out, inf, zero, done
  );

  modport slave (
    input  in1, in2, start,
    output out, inf, zero, done
  );
endinterface

// File: rtl/posit_mult.sv
// Posit<N,es> multiplier: combinational decode/multiply/round, one registered
// result stage; accepts one operand pair per cycle when start is high.
module posit_mult #(
  parameter int N  = 8,
  parameter int es = 3
) (
  input  logic         clk,
  input  logic         rst,
  posit_mult_if.slave  bus
);
  localparam int Bs = $clog2(N);
  localparam int KW = Bs + 1;            // signed regime value
  localparam int W  = N - es;            // mantissa width incl. hidden bit
  localparam int PW = 2 * W;             // raw mantissa product width
  localparam int FW = PW - 1;            // fraction after normalisation
  localparam int SW = Bs + es + 4;       // signed scale width
  localparam int T  = es + FW;           // exponent + fraction tail
  localparam int V  = 2 + T + N - 1;     // regime seed + tail + shift headroom

  localparam logic [N-1:0]          NAR   = {1'b1, {(N-1){1'b0}}};
  localparam logic signed [SW-1:0]  K_MAX = SW'(N - 2);
  localparam logic signed [SW-1:0]  K_MIN = SW'(-(N - 1));

  logic [N-1:0]          opnd [2];
  logic                  s_a  [2];
  logic signed [KW-1:0]  k_a  [2];
  logic [es-1:0]         e_a  [2];
  logic [W-1:0]          mt_a [2];

  assign opnd[0] = bus.in1;
  assign opnd[1] = bus.in2;

  // Operand decode: magnitude, regime run length, exponent, mantissa with hidden 1
  for (genvar gi = 0; gi < 2; gi++) begin : g_dec
    logic [N-2:0]          rem;
    logic [N-2:0]          sh;
    logic                  r0;
    logic                  run;
    logic [Bs-1:0]         m;
    logic signed [KW-1:0]  km;
    logic signed [KW-1:0]  k;

    always_comb begin
      rem = opnd[gi][N-1] ? (~opnd[gi][N-2:0] + 1'b1) : opnd[gi][N-2:0];
      r0  = rem[N-2];
      run = 1'b1;
      m   = '0;
      for (int i = N - 2; i >= 0; i--) begin
        if (run && (rem[i] == r0)) m = m + 1'b1;
        else                       run = 1'b0;
      end
      km = {1'b0, m};
      k  = r0 ? (km - KW'(1)) : -km;
      // Drop regime run and its terminator; bits shifted past the end read as zero
      sh = (rem << m) << 1;
    end

    assign s_a[gi]  = opnd[gi][N-1];
    assign k_a[gi]  = k;
    assign e_a[gi]  = sh[N-2 -: es];
    assign mt_a[gi] = {1'b1, sh[N-2-es:0]};
  end

  logic                  sign;
  logic [PW-1:0]         prod;
  logic [FW-1:0]         fracp;
  logic signed [SW-1:0]  ksum0;
  logic signed [SW-1:0]  ksum1;
  logic signed [SW-1:0]  scale;
  logic signed [SW-1:0]  kr;
  logic [SW-1:0]         shamt;
  logic [es-1:0]         er;
  logic [T-1:0]          tail;
  logic signed [V-1:0]   base_pos;
  logic [V-1:0]          base_neg;
  logic [V-1:0]          vec;
  logic [N-2:0]          trunc;
  logic                  guard;
  logic                  sticky;
  logic [N-2:0]          mag;
  logic [N-1:0]          res_mag;
  logic                  nar_in;
  logic                  zero_in;

  logic [N-1:0] out_d,  out_q;
  logic         inf_d,  inf_q;
  logic         zero_d, zero_q;
  logic         done_q;

  always_comb begin
    sign  = s_a[0] ^ s_a[1];
    prod  = mt_a[0] * mt_a[1];
    ksum0 = {{(SW-KW){k_a[0][KW-1]}}, k_a[0]};
    ksum1 = {{(SW-KW){k_a[1][KW-1]}}, k_a[1]};
    scale = ((ksum0 + ksum1) <<< es) + SW'(e_a[0]) + SW'(e_a[1]);
    if (prod[PW-1]) begin
      fracp = prod[PW-2:0];
      scale = scale + SW'(1);
    end else begin
      fracp = {prod[PW-3:0], 1'b0};
    end

    kr    = scale >>> es;
    er    = scale[es-1:0];
    tail  = {er, fracp};
    shamt = kr[SW-1] ? ~kr : kr;

    // Seed "10"/"01" and shift: arithmetic shift grows a ones-run, logical a zeros-run
    base_pos = {2'b10, tail, {(N-1){1'b0}}};
    base_neg = {2'b01, tail, {(N-1){1'b0}}};
    if (kr[SW-1]) vec = base_neg >> shamt;
    else          vec = base_pos >>> shamt;

    trunc  = vec[V-1 -: N-1];
    guard  = vec[V-N];
    sticky = |vec[V-N-1:0];
    mag    = trunc + {{(N-2){1'b0}}, guard & (trunc[0] | sticky)};

    if (kr >= K_MAX)      mag = {(N-1){1'b1}};
    else if (kr <= K_MIN) mag = {{(N-2){1'b0}}, 1'b1};

    res_mag = {1'b0, mag};
    nar_in  = (opnd[0] == NAR) || (opnd[1] == NAR);
    zero_in = (opnd[0] == '0)  || (opnd[1] == '0);

    out_d  = sign ? (~res_mag + 1'b1) : res_mag;
    inf_d  = 1'b0;
    zero_d = 1'b0;
    if (nar_in) begin
      out_d = NAR;
      inf_d = 1'b1;
    end else if (zero_in) begin
      out_d  = '0;
      zero_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_q  <= '0;
      inf_q  <= 1'b0;
      zero_q <= 1'b0;
      done_q <= 1'b0;
    end else if (bus.start) begin
      out_q  <= out_d;
      inf_q  <= inf_d;
      zero_q <= zero_d;
      done_q <= 1'b1;
    end else begin
      done_q <= 1'b0;
    end
  end

  assign bus.out  = out_q;
  assign bus.inf  = inf_q;
  assign bus.zero = zero_q;
  assign bus.done = done_q;
endmodule

// File: tb/tb_posit_mult.sv
// Bench for posit_mult (N=8, es=3): directed vectors, exhaustive sweep and
// random start patterns against a real-valued posit reference model.
module tb_posit_mult;
  localparam int N  = 8;
  localparam int ES = 3;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  posit_mult_if #(.N(N)) bus ();

  posit_mult #(.N(N), .es(ES)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int tests = 0;
  int fails = 0;

  real val8 [128];
  real mid9 [128];

  function automatic real pow2(input int s);
    real r;
    r = 1.0;
    if (s >= 0) for (int j = 0; j < s; j++) r = r * 2.0;
    else        for (int j = 0; j < -s; j++) r = r / 2.0;
    return r;
  endfunction

  // Value of a positive nb-bit posit code, straight from the regime/exponent/fraction rules
  function automatic real pdec(input int code, input int nb);
    int  i, m, k, e, r0;
    real f, w;
    r0 = (code >> (nb - 2)) & 1;
    m  = 0;
    i  = nb - 2;
    while (i >= 0 && ((code >> i) & 1) == r0) begin
      m++;
      i--;
    end
    k = (r0 == 1) ? m - 1 : -m;
    i--;
    e = 0;
    for (int j = 0; j < ES; j++) begin
      e = e * 2;
      if (i >= 0) begin
        e = e + ((code >> i) & 1);
        i--;
      end
    end
    f = 1.0;
    w = 0.5;
    while (i >= 0) begin
      if (((code >> i) & 1) == 1) f = f + w;
      w = w / 2.0;
      i--;
    end
    return pow2(k * (1 << ES) + e) * f;
  endfunction

  // Nearest 7-bit magnitude code; bit-string midpoints are the 9-bit codes a||1
  function automatic logic [6:0] round_mag(input real v);
    if (v >= val8[127]) return 7'd127;
    if (v <= val8[1])   return 7'd1;
    for (int a = 1; a < 127; a++) begin
      if (v >= val8[a] && v < val8[a+1]) begin
        if (v == val8[a])  return 7'(a);
        if (v < mid9[a])   return 7'(a);
        if (v > mid9[a])   return 7'(a + 1);
        return (a % 2 == 0) ? 7'(a) : 7'(a + 1);
      end
    end
    return 7'd0;
  endfunction

  task automatic model(input logic [7:0] a, input logic [7:0] b,
                       output logic [7:0] o, output logic i, output logic z);
    logic [7:0] ma, mb, r;
    real        v;
    o = 8'h00; i = 1'b0; z = 1'b0;
    if (a == 8'h80 || b == 8'h80) begin
      o = 8'h80; i = 1'b1;
    end else if (a == 8'h00 || b == 8'h00) begin
      z = 1'b1;
    end else begin
      ma = a[7] ? -a : a;
      mb = b[7] ? -b : b;
      v  = pdec(int'(ma), 8) * pdec(int'(mb), 8);
      r  = {1'b0, round_mag(v)};
      o  = (a[7] ^ b[7]) ? -r : r;
    end
  endtask

  task automatic apply(input logic [7:0] a, input logic [7:0] b, input logic st);
    bus.in1   = a;
    bus.in2   = b;
    bus.start = st;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    apply(8'h40, 8'h44, 1'b1);
    apply(8'h40, 8'h44, 1'b1);
    $display("[TB] reset: out=%h inf=%b zero=%b done=%b", bus.out, bus.inf, bus.zero, bus.done);
    tests++; if (bus.out !== 8'h00) begin fails++; $display("FAIL reset_out got=%h exp=00", bus.out); end
    tests++; if (bus.inf !== 1'b0) begin fails++; $display("FAIL reset_inf got=%b exp=0", bus.inf); end
    tests++; if (bus.zero !== 1'b0) begin fails++; $display("FAIL reset_zero got=%b exp=0", bus.zero); end
    tests++; if (bus.done !== 1'b0) begin fails++; $display("FAIL reset_done got=%b exp=0", bus.done); end
    rst = 1'b0;
    apply(8'h40, 8'h44, 1'b1);
    $display("[TB] first after reset: out=%h done=%b", bus.out, bus.done);
    tests++; if (bus.done !== 1'b1) begin fails++; $display("FAIL first_done got=%b exp=1", bus.done); end
    tests++; if (bus.out !== 8'h44) begin fails++; $display("FAIL first_out got=%h exp=44", bus.out); end
  endtask

  task automatic test_directed();
    logic [7:0] ta [10] = '{8'h40, 8'hC0, 8'h42, 8'h42, 8'h7F, 8'h01, 8'h81, 8'h80, 8'h00, 8'h00};
    logic [7:0] tb [10] = '{8'h44, 8'h40, 8'h42, 8'hC0, 8'h7F, 8'h01, 8'h7F, 8'h40, 8'h80, 8'h42};
    logic [7:0] to [10] = '{8'h44, 8'hC0, 8'h44, 8'hBE, 8'h7F, 8'h01, 8'h81, 8'h80, 8'h80, 8'h00};
    logic       ti [10] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    logic       tz [10] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    for (int j = 0; j < 10; j++) begin
      apply(ta[j], tb[j], 1'b1);
      $display("[TB] directed %h*%h -> out=%h inf=%b zero=%b done=%b",
               ta[j], tb[j], bus.out, bus.inf, bus.zero, bus.done);
      tests++;
      if (bus.out !== to[j] || bus.inf !== ti[j] || bus.zero !== tz[j] || bus.done !== 1'b1) begin
        fails++;
        $display("FAIL directed_%h_%h got out=%h inf=%b zero=%b done=%b exp out=%h inf=%b zero=%b done=1",
                 ta[j], tb[j], bus.out, bus.inf, bus.zero, bus.done, to[j], ti[j], tz[j]);
      end
    end
  endtask

  task automatic test_start_gap();
    logic [7:0] eo; logic ei, ez;
    apply(8'h42, 8'h42, 1'b1);
    apply(8'h7F, 8'h01, 1'b0);
    $display("[TB] start gap: out=%h done=%b", bus.out, bus.done);
    tests++; if (bus.done !== 1'b0) begin fails++; $display("FAIL gap_done got=%b exp=0", bus.done); end
    tests++; if (bus.out !== 8'h44) begin fails++; $display("FAIL gap_hold got=%h exp=44", bus.out); end
    model(8'h7F, 8'h01, eo, ei, ez);
    apply(8'h7F, 8'h01, 1'b1);
    $display("[TB] 7f*01 -> out=%h done=%b", bus.out, bus.done);
    tests++;
    if (bus.out !== eo || bus.done !== 1'b1) begin
      fails++; $display("FAIL gap_resume got=%h/%b exp=%h/1", bus.out, bus.done, eo);
    end
  endtask

  task automatic test_midstream_reset();
    apply(8'h44, 8'h44, 1'b1);
    rst = 1'b1;
    apply(8'h44, 8'h44, 1'b1);
    rst = 1'b0;
    $display("[TB] midstream reset: out=%h done=%b", bus.out, bus.done);
    tests++;
    if (bus.out !== 8'h00 || bus.done !== 1'b0) begin
      fails++; $display("FAIL midreset got out=%h done=%b exp out=00 done=0", bus.out, bus.done);
    end
  endtask

  task automatic test_sweep();
    logic [7:0] eo; logic ei, ez;
    int bad;
    for (int a = 0; a < 256; a++) begin
      bad = 0;
      for (int b = 0; b < 256; b++) begin
        model(8'(a), 8'(b), eo, ei, ez);
        apply(8'(a), 8'(b), 1'b1);
        tests++;
        if (bus.out !== eo || bus.inf !== ei || bus.zero !== ez || bus.done !== 1'b1) begin
          fails++; bad++;
          $display("FAIL sweep_%h_%h got out=%h inf=%b zero=%b done=%b exp out=%h inf=%b zero=%b done=1",
                   8'(a), 8'(b), bus.out, bus.inf, bus.zero, bus.done, eo, ei, ez);
        end
      end
      $display("[TB] sweep in1=%h: 256 pairs, %0d wrong", 8'(a), bad);
    end
  endtask

  task automatic test_random();
    logic [7:0] a, b, eo, no; logic st, ei, ez, ni, nz, ed;
    eo = bus.out; ei = bus.inf; ez = bus.zero;
    for (int j = 0; j < 2000; j++) begin
      a  = 8'($urandom);
      b  = 8'($urandom);
      st = ($urandom_range(0, 3) != 0);
      model(a, b, no, ni, nz);
      if (st) begin eo = no; ei = ni; ez = nz; end
      ed = st;
      apply(a, b, st);
      tests++;
      if (bus.out !== eo || bus.inf !== ei || bus.zero !== ez || bus.done !== ed) begin
        fails++;
        $display("FAIL random_%h_%h_st%b got out=%h inf=%b zero=%b done=%b exp out=%h inf=%b zero=%b done=%b",
                 a, b, st, bus.out, bus.inf, bus.zero, bus.done, eo, ei, ez, ed);
      end
    end
    $display("[TB] random: 2000 cycles done");
  endtask

  initial begin
    for (int p = 1; p < 128; p++) val8[p] = pdec(p, 8);
    for (int p = 1; p < 127; p++) mid9[p] = pdec(2 * p + 1, 9);
    val8[0] = 0.0; mid9[0] = 0.0; mid9[127] = 0.0;
    rst = 1'b1; bus.in1 = '0; bus.in2 = '0; bus.start = 1'b0;
    test_reset();
    test_directed();
    test_start_gap();
    test_midstream_reset();
    test_sweep();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
